// File: rtl/pe_result_drain_if.sv
// Valid/ready result-drain bus between the PE block result side and the
// output buffer / DMA writer. The drain block is the master of the stream.
interface pe_result_drain_if #(
    parameter int ARRAY_NUM = 3,
    parameter int BLOCK_NUM = 3
) ();
    logic                             iCapture;
    logic [8*ARRAY_NUM*BLOCK_NUM-1:0] iResult;
    logic                             oClearAcc;
    logic                             oBusy;
    logic [8*ARRAY_NUM-1:0]           oData;
    logic                             oValid;
    logic                             iReady;
    logic                             oLast;
    logic                             oOverrun;

    modport master (
        input  iCapture, iResult, iReady,
        output oClearAcc, oBusy, oData, oValid, oLast, oOverrun
    );

    modport slave (
        output iCapture, iResult, iReady,
        input  oClearAcc, oBusy, oData, oValid, oLast, oOverrun
    );
endinterface

// File: rtl/pe_result_drain.sv
// Snapshots the PE block accumulator bus in one cycle and streams it out one
// array slice per beat. Clears the accumulators as soon as the snapshot is
// taken so the next accumulation overlaps the drain.
module pe_result_drain #(
    parameter int ARRAY_NUM = 3,
    parameter int BLOCK_NUM = 3
) (
    input  logic             iClk,
    input  logic             iRst,
    pe_result_drain_if.master bus
);
    localparam int BEAT_W  = 8 * ARRAY_NUM;
    localparam int SNAP_W  = BEAT_W * BLOCK_NUM;
    localparam int IDX_W   = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_NUM - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SNAP_W-1:0]  shadow_q, shadow_d;
    logic               clear_q, clear_d;
    logic               overrun_q, overrun_d;

    logic               last_beat;
    logic               handshake;

    // Outputs decode registered state only; iReady and iCapture never reach them.
    assign last_beat     = (state_q == SEND) && (idx_q == LAST_IDX);
    assign handshake     = (state_q == SEND) && bus.iReady;

    assign bus.oValid    = (state_q == SEND);
    assign bus.oBusy     = (state_q == SEND);
    assign bus.oLast     = last_beat;
    assign bus.oClearAcc = clear_q;
    assign bus.oOverrun  = overrun_q;
    assign bus.oData     = (state_q == SEND) ? shadow_q[int'(idx_q)*BEAT_W +: BEAT_W]
                                             : '0;

    // Next-state logic: capture, beat advance, back-to-back reload and overrun.
    always_comb begin
        // NOTE: every signal gets a hold value first so no path can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        clear_d   = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (bus.iCapture) begin
                    shadow_d = bus.iResult;
                    idx_d    = '0;
                    clear_d  = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (handshake && last_beat) begin
                    // Final beat accepted: a same-cycle capture reloads with no bubble.
                    idx_d = '0;
                    if (bus.iCapture) begin
                        shadow_d = bus.iResult;
                        clear_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    // Snapshot still in flight: the new result has nowhere to go.
                    if (bus.iCapture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; a reset discards any partially drained snapshot.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            // NOTE: the shadow is reset too, so oData reads zero right after reset
            // rather than a stale snapshot.
            shadow_q  <= '0;
            clear_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            clear_q   <= clear_d;
            overrun_q <= overrun_d;
        end
    end
endmodule
